// File: rtl/hex_page_select.sv
// Front-end for the seven-segment debug display: debounced page stepping,
// optional timed auto-scroll, and freezable page value registers.
module hex_page_select #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCROLL_CYCLES   = 50000000,
  parameter int CNT_W           = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_n,
  input  logic       auto_en,
  input  logic       hold,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  output logic [1:0] select,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic       press_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SCR_LAST = CNT_W'(SCROLL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  deb_state_t       r_state;
  deb_state_t       w_state_next;
  logic [CNT_W-1:0] r_dcnt;
  logic [CNT_W-1:0] w_dcnt_next;
  logic             w_pulse_next;
  logic             r_press_pulse;
  logic [CNT_W-1:0] r_scnt;
  logic             w_tick;
  logic             w_step;
  logic [1:0]       r_select;
  logic [7:0]       r_out0;
  logic [7:0]       r_out1;
  logic [7:0]       r_out2;
  logic [7:0]       r_out3;

  // Synchronizer resets to "released" so a reset never looks like a press.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_dcnt        <= '0;
      r_press_pulse <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_dcnt        <= w_dcnt_next;
      r_press_pulse <= w_pulse_next;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_dcnt_next  = r_dcnt;
    w_pulse_next = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!r_sync2) begin
          w_state_next = PRESS_WAIT;
          w_dcnt_next  = CNT_ONE;
        end else begin
          w_dcnt_next  = '0;
        end
      end
      PRESS_WAIT: begin
        if (r_sync2) begin
          w_state_next = IDLE;
          w_dcnt_next  = '0;
        end else if (r_dcnt == DEB_LAST) begin
          w_state_next = PRESSED;
          w_dcnt_next  = '0;
          w_pulse_next = 1'b1;
        end else begin
          w_dcnt_next  = r_dcnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (r_sync2) begin
          w_state_next = RELEASE_WAIT;
          w_dcnt_next  = CNT_ONE;
        end else begin
          w_dcnt_next  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!r_sync2) begin
          w_state_next = PRESSED;
          w_dcnt_next  = '0;
        end else if (r_dcnt == DEB_LAST) begin
          w_state_next = IDLE;
          w_dcnt_next  = '0;
        end else begin
          w_dcnt_next  = r_dcnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_dcnt_next  = '0;
      end
    endcase
  end

  // A manual step restarts the scroll period; a coincident tick still
  // advances select only once.
  assign w_tick = auto_en && (r_scnt == SCR_LAST);
  assign w_step = r_press_pulse || w_tick;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_scnt   <= '0;
      r_select <= 2'd0;
    end else begin
      if (!auto_en || w_step) r_scnt <= '0;
      else                    r_scnt <= r_scnt + CNT_ONE;
      if (w_step) r_select <= r_select + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_out0 <= 8'h00;
      r_out1 <= 8'h00;
      r_out2 <= 8'h00;
      r_out3 <= 8'h00;
    end else if (!hold) begin
      r_out0 <= in0;
      r_out1 <= in1;
      r_out2 <= in2;
      r_out3 <= in3;
    end
  end

  assign select      = r_select;
  assign press_pulse = r_press_pulse;
  assign out0        = r_out0;
  assign out1        = r_out1;
  assign out2        = r_out2;
  assign out3        = r_out3;

endmodule

// File: tb/tb_hex_page_select.sv
// Bench for hex_page_select: directed timing scenarios, a hold vector table,
// and random traffic compared cycle by cycle against a run-length key model.
module tb_hex_page_select;

  localparam int D = 4;
  localparam int S = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       key_n = 1'b1;
  logic       auto_en = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] in0 = 8'h00, in1 = 8'h00, in2 = 8'h00, in3 = 8'h00;
  logic [1:0] select;
  logic [7:0] out0, out1, out2, out3;
  logic       press_pulse;

  hex_page_select #(.DEBOUNCE_CYCLES(D), .SCROLL_CYCLES(S), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .key_n(key_n), .auto_en(auto_en),
    .hold(hold), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .select(select), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .press_pulse(press_pulse)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int pulse_seen = 0;

  // Reference model: key acceptance expressed as "D consecutive synchronized
  // samples differing from the accepted level".
  logic       m_sync1, m_sync2;
  logic       m_level;
  int         m_run;
  logic       m_pulse;
  int         m_scnt;
  int         m_sel;
  logic [7:0] m_out [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic tick;
    logic k;
    if (!reset) begin
      m_sync1 = 1'b1; m_sync2 = 1'b1; m_level = 1'b1; m_run = 0;
      m_pulse = 1'b0; m_scnt = 0; m_sel = 0;
      for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
      return;
    end
    tick = auto_en && (m_scnt == S - 1);
    k    = m_sync2;
    if (m_pulse || tick) m_sel = (m_sel + 1) % 4;
    if (!auto_en || m_pulse || tick) m_scnt = 0;
    else                             m_scnt = m_scnt + 1;
    m_pulse = 1'b0;
    if (k == m_level) m_run = 0;
    else begin
      m_run = m_run + 1;
      if (m_run == D) begin
        m_level = k;
        m_run   = 0;
        m_pulse = (k == 1'b0);
      end
    end
    m_sync2 = m_sync1;
    m_sync1 = key_n;
    if (!hold) begin
      m_out[0] = in0; m_out[1] = in1; m_out[2] = in2; m_out[3] = in3;
    end
  endtask

  task automatic compare_model();
    check("select", 32'(select), 32'(m_sel));
    check("press_pulse", 32'(press_pulse), 32'(m_pulse));
    check("out0", 32'(out0), 32'(m_out[0]));
    check("out1", 32'(out1), 32'(m_out[1]));
    check("out2", 32'(out2), 32'(m_out[2]));
    check("out3", 32'(out3), 32'(m_out[3]));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_edge();
      #1;
      compare_model();
      if (press_pulse === 1'b1) pulse_seen++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; key_n = 1'b1; auto_en = 1'b0; hold = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  typedef struct {
    logic       hold;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [7:0] exp1;
    logic [7:0] exp2;
  } hold_vec_t;

  hold_vec_t vecs [11];

  initial begin
    int key_run;

    vecs[0]  = '{1'b0, 8'h12, 8'h56, 8'h12, 8'h56};
    vecs[1]  = '{1'b1, 8'h12, 8'h56, 8'h12, 8'h56};
    vecs[2]  = '{1'b1, 8'h34, 8'h78, 8'h12, 8'h56};
    vecs[3]  = '{1'b1, 8'h34, 8'h78, 8'h12, 8'h56};
    vecs[4]  = '{1'b1, 8'h34, 8'h78, 8'h12, 8'h56};
    vecs[5]  = '{1'b1, 8'h34, 8'h78, 8'h12, 8'h56};
    vecs[6]  = '{1'b1, 8'h34, 8'h78, 8'h12, 8'h56};
    vecs[7]  = '{1'b0, 8'h34, 8'h78, 8'h34, 8'h78};
    vecs[8]  = '{1'b0, 8'h9A, 8'hBC, 8'h9A, 8'hBC};
    vecs[9]  = '{1'b1, 8'h00, 8'hFF, 8'h9A, 8'hBC};
    vecs[10] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};

    // Reset values, then first load after release.
    in0 = 8'hAA;
    reset = 1'b0;
    step(2);
    check("rst_select", 32'(select), 32'd0);
    check("rst_out0", 32'(out0), 32'h00);
    check("rst_out3", 32'(out3), 32'h00);
    check("rst_pulse", 32'(press_pulse), 32'd0);
    reset = 1'b1;
    step(1);
    check("rel_out0", 32'(out0), 32'hAA);

    // Bounce shorter than D must not produce a pulse.
    do_reset();
    pulse_seen = 0;
    key_n = 1'b0; step(2);
    key_n = 1'b1; step(1);
    key_n = 1'b0; step(2);
    key_n = 1'b1; step(8);
    check("bounce_pulses", 32'(pulse_seen), 32'd0);
    check("bounce_select", 32'(select), 32'd0);

    // Clean press: pulse in the 6th cycle after the first low sample.
    pulse_seen = 0;
    key_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (i == 5) check("press_early", 32'(press_pulse), 32'd0);
      if (i == 6) check("press_latency", 32'(press_pulse), 32'd1);
      if (i == 7) check("press_select", 32'(select), 32'd1);
    end
    key_n = 1'b1; step(10);
    check("press_count", 32'(pulse_seen), 32'd1);

    // Three more full presses: select 2, 3, then wraps to 0.
    for (int p = 0; p < 3; p++) begin
      key_n = 1'b0; step(8);
      key_n = 1'b1; step(8);
      check("press_wrap", 32'(select), 32'((p + 2) % 4));
    end

    // Auto-scroll from reset release.
    do_reset();
    auto_en = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      step(1);
      if (k == 9) check("scroll_pre", 32'(select), 32'd0);
      if (k % 10 == 0) check("scroll_tick", 32'(select), 32'((k / 10) % 4));
    end
    auto_en = 1'b0; step(15);
    check("scroll_off", 32'(select), 32'd0);
    auto_en = 1'b1; step(9);
    check("scroll_restart_pre", 32'(select), 32'd0);
    step(1);
    check("scroll_restart", 32'(select), 32'd1);

    // Press pulse coinciding with the tick: single increment.
    do_reset();
    auto_en = 1'b1;
    step(3);
    key_n = 1'b0; step(6);
    check("coll_pulse", 32'(press_pulse), 32'd1);
    step(1);
    check("coll_select", 32'(select), 32'd1);
    step(9);
    check("coll_next_pre", 32'(select), 32'd1);
    step(1);
    check("coll_next", 32'(select), 32'd2);
    key_n = 1'b1; auto_en = 1'b0; step(8);

    // Hold vector table.
    do_reset();
    for (int v = 0; v < 11; v++) begin
      hold = vecs[v].hold; in1 = vecs[v].in1; in2 = vecs[v].in2;
      step(1);
      check("hold_out1", 32'(out1), 32'(vecs[v].exp1));
      check("hold_out2", 32'(out2), 32'(vecs[v].exp2));
    end

    // Random traffic against the model.
    do_reset();
    key_run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (key_run == 0) begin
        key_n   = ~key_n;
        key_run = $urandom_range(1, 9);
      end else key_run--;
      if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 9) == 0)  hold = ~hold;
      in0 = 8'($urandom); in1 = 8'($urandom);
      in2 = 8'($urandom); in3 = 8'($urandom);
      reset = ($urandom_range(0, 299) != 0);
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
